// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and write-back source indices for the bypassing register file.
package rf_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRD  = 2;
  localparam int RF_NSRC = 3;
  localparam int SRC_IEU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_PC  = 2;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with set/clear and per-port hazard lookup.
module rf_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sb_set,
  input  logic [$clog2(NREG)-1:0]       sb_set_addr,
  input  logic                          sb_clr,
  input  logic [$clog2(NREG)-1:0]       sb_clr_addr,
  input  logic [NRD*$clog2(NREG)-1:0]   rs_addr,
  output logic [NRD-1:0]                rs_busy
);
  localparam int AW = $clog2(NREG);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_next;
  // set is applied after clear so a same-cycle set wins; x0 is forced idle
  always_comb begin
    w_next = r_busy;
    if (sb_clr) w_next[sb_clr_addr] = 1'b0;
    if (sb_set) w_next[sb_set_addr] = 1'b1;
    w_next[0] = 1'b0;
  end
  always_ff @(posedge clk) r_busy <= reset ? '0 : w_next;
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] w_a;
    assign w_a = rs_addr[i*AW +: AW];
    assign rs_busy[i] = r_busy[w_a] & ~(sb_clr && sb_clr_addr == w_a);
  end
endmodule

// File: rtl/rf_bypass_sb.sv
// rf_bypass_sb: register file with priority write-back select, write-to-read bypass
// and a busy scoreboard for long-latency results.
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = RF_NRD,
  parameter int NSRC = RF_NSRC,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rs_addr,
  output logic [NRD*XLEN-1:0]  rs_data,
  output logic [NRD-1:0]       rs_busy,
  input  logic [AW-1:0]        rd_addr,
  input  logic [NSRC-1:0]      wb_valid,
  input  logic [NSRC*XLEN-1:0] wb_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_clr,
  input  logic [AW-1:0]        sb_clr_addr,
  output logic                 wb_conflict
);
  logic [XLEN-1:0] r_mem [1:NREG-1];
  logic            w_rd_we;
  logic [XLEN-1:0] w_rd_data;
  logic            r_conflict;
  assign w_rd_we = |wb_valid;
  // later iterations overwrite earlier ones, giving the highest index priority
  always_comb begin
    w_rd_data = '0;
    for (int s = 0; s < NSRC; s++)
      if (wb_valid[s]) w_rd_data = wb_data[s*XLEN +: XLEN];
  end
  always_ff @(posedge clk)
    if (!reset && w_rd_we && rd_addr != '0) r_mem[rd_addr] <= w_rd_data;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] r_rs;
    assign w_a = rs_addr[i*AW +: AW];
    always_ff @(posedge clk)
      r_rs <= reset ? '0 : (w_a == '0) ? '0 : (w_rd_we && rd_addr == w_a) ? w_rd_data : r_mem[w_a];
    assign rs_data[i*XLEN +: XLEN] = r_rs;
  end
  always_ff @(posedge clk) r_conflict <= reset ? 1'b0 : ($countones(wb_valid) > 1);
  assign wb_conflict = r_conflict;
  rf_scoreboard #(.NREG(NREG), .NRD(NRD)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .sb_clr      (sb_clr),
    .sb_clr_addr (sb_clr_addr),
    .rs_addr     (rs_addr),
    .rs_busy     (rs_busy)
  );
endmodule
